// File: rtl/value_range_checker_if.sv
// value_range_checker_if
//   Valid/ready stream bundle between a sample producer, the range checker
//   and a result consumer.
//   slave  : checker side  (consumes in_*, produces out_*)
//   master : environment side (produces in_*, consumes out_*)
//   in_valid/in_ready/in_data        : incoming signed samples
//   out_valid/out_ready              : result handshake
//   out_data/out_clamped/out_class   : pass-through, clamped value, class
interface value_range_checker_if #(
  parameter int W = 16
) ();
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_data;
  logic signed [W-1:0] out_clamped;
  logic [1:0]          out_class;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_clamped, out_class
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_clamped, out_class
  );
endinterface

// File: rtl/value_range_checker.sv
// value_range_checker
//   Checks a stream of signed samples against the range from [LO:HI]
//   (bound inclusivity set by LO_INCL/HI_INCL) with an optional exclude
//   window [EX_LO:EX_HI). One registered pipeline stage, valid/ready on both
//   sides, 1 sample/cycle.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : stream interface (slave modport)
//   clr         : synchronous clear of statistics and sticky error state
//   err         : sticky, a violation has been accepted since reset/clr
//   n_samples   : accepted samples, saturating
//   n_viol      : accepted violations, saturating
//   first_viol  : first violating sample since reset/clr
module value_range_checker #(
  parameter int W       = 16,
  parameter int LO      = -10,
  parameter int HI      = 10,
  parameter int LO_INCL = 1,
  parameter int HI_INCL = 1,
  parameter int EX_EN   = 1,
  parameter int EX_LO   = 1,
  parameter int EX_HI   = 2,
  parameter int CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  value_range_checker_if.slave    bus,
  input  logic                    clr,
  output logic                    err,
  output logic [CNT_W-1:0]        n_samples,
  output logic [CNT_W-1:0]        n_viol,
  output logic signed [W-1:0]     first_viol
);

  typedef enum logic [1:0] {
    CLS_OK    = 2'd0,
    CLS_BELOW = 2'd1,
    CLS_ABOVE = 2'd2,
    CLS_EXCL  = 2'd3
  } cls_e;

  typedef enum logic {
    CLEAN = 1'b0,
    FAULT = 1'b1
  } state_e;

  // Bounds widened by one bit so comparisons never overflow at the edges
  // of the W-bit range (e.g. LO = -2^(W-1)).
  localparam logic signed [W:0]   LO_X     = (W+1)'(LO);
  localparam logic signed [W:0]   HI_X     = (W+1)'(HI);
  localparam logic signed [W:0]   EX_LO_X  = (W+1)'(EX_LO);
  localparam logic signed [W:0]   EX_HI_X  = (W+1)'(EX_HI);
  localparam bit                  EX_ON    = (EX_EN != 0) && (EX_LO < EX_HI);
  localparam logic signed [W-1:0] CLAMP_LO = W'(LO_INCL != 0 ? LO : LO + 1);
  localparam logic signed [W-1:0] CLAMP_HI = W'(HI_INCL != 0 ? HI : HI - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX  = '1;

  logic signed [W:0]   x_ext;
  logic                below, above, excluded;
  cls_e                cls;
  logic signed [W-1:0] clamped;
  logic                accept;
  logic                viol;
  state_e              state_q;

  assign x_ext    = {bus.in_data[W-1], bus.in_data};
  assign below    = (x_ext < LO_X) || ((LO_INCL == 0) && (x_ext == LO_X));
  assign above    = (x_ext > HI_X) || ((HI_INCL == 0) && (x_ext == HI_X));
  assign excluded = EX_ON && (x_ext >= EX_LO_X) && (x_ext < EX_HI_X);

  // NOTE: every output of this block gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cls     = CLS_OK;
    clamped = bus.in_data;
    if (below) begin
      cls     = CLS_BELOW;
      clamped = CLAMP_LO;
    end else if (above) begin
      cls     = CLS_ABOVE;
      clamped = CLAMP_HI;
    end else if (excluded) begin
      cls = CLS_EXCL;
    end
  end

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign viol         = (cls != CLS_OK);

  // Result register. Fields only load on accept, so they hold while the
  // consumer stalls.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      bus.out_clamped <= '0;
      bus.out_class   <= CLS_OK;
    end else if (accept) begin
      bus.out_valid   <= 1'b1;
      bus.out_data    <= bus.in_data;
      bus.out_clamped <= clamped;
      bus.out_class   <= cls;
    end else if (bus.out_ready) begin
      bus.out_valid   <= 1'b0;
    end
  end

  // Sticky error FSM and statistics. clr wipes history, then a sample
  // accepted on the same edge is applied on top of the cleared state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAN;
      n_samples  <= '0;
      n_viol     <= '0;
      first_viol <= '0;
    end else if (clr) begin
      n_samples  <= accept ? CNT_W'(1) : '0;
      n_viol     <= (accept && viol) ? CNT_W'(1) : '0;
      state_q    <= (accept && viol) ? FAULT : CLEAN;
      first_viol <= (accept && viol) ? bus.in_data : '0;
    end else if (accept) begin
      if (n_samples != CNT_MAX) n_samples <= n_samples + 1'b1;
      if (viol) begin
        if (n_viol != CNT_MAX) n_viol <= n_viol + 1'b1;
        if (state_q == CLEAN) begin
          state_q    <= FAULT;
          first_viol <= bus.in_data;
        end
      end
    end
  end

  assign err = (state_q == FAULT);

endmodule

// File: tb/tb_value_range_checker.sv
module tb_value_range_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- DUT A: default parameters ----------------
  value_range_checker_if #(.W(16)) a_if ();
  logic              clr_a;
  logic              err_a;
  logic [7:0]        ns_a, nv_a;
  logic signed [15:0] fv_a;

  value_range_checker u_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if), .clr(clr_a),
    .err(err_a), .n_samples(ns_a), .n_viol(nv_a), .first_viol(fv_a)
  );

  // ---------------- DUT B: exclusive bounds, 4-bit counters ----------------
  value_range_checker_if #(.W(16)) b_if ();
  logic              err_b;
  logic [3:0]        ns_b, nv_b;
  logic signed [15:0] fv_b;

  value_range_checker #(.LO_INCL(0), .HI_INCL(0), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if), .clr(1'b0),
    .err(err_b), .n_samples(ns_b), .n_viol(nv_b), .first_viol(fv_b)
  );

  // ---------------- DUT C: 8-bit full range, no exclude ----------------
  value_range_checker_if #(.W(8)) c_if ();
  logic              err_c;
  logic [7:0]        ns_c, nv_c;
  logic signed [7:0] fv_c;

  value_range_checker #(.W(8), .LO(-128), .HI(127), .EX_EN(0)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(c_if), .clr(1'b0),
    .err(err_c), .n_samples(ns_c), .n_viol(nv_c), .first_viol(fv_c)
  );

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Range rules evaluated with plain integer arithmetic (no width limits).
  function automatic void ref_class(input int x, input int lo, input int hi,
                                    input int lo_incl, input int hi_incl,
                                    input int ex_en, input int ex_lo,
                                    input int ex_hi, output int cls,
                                    output int clamp);
    if (x < lo || (x == lo && lo_incl == 0)) begin
      cls = 1; clamp = (lo_incl != 0) ? lo : lo + 1;
    end else if (x > hi || (x == hi && hi_incl == 0)) begin
      cls = 2; clamp = (hi_incl != 0) ? hi : hi - 1;
    end else if (ex_en != 0 && ex_lo < ex_hi && x >= ex_lo && x < ex_hi) begin
      cls = 3; clamp = x;
    end else begin
      cls = 0; clamp = x;
    end
  endfunction

  // Transaction-level model of DUT A.
  bit m_valid;
  int m_data, m_clamp, m_cls;
  int m_ns, m_nv, m_err, m_fv;

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_clamp = 0; m_cls = 0;
    m_ns = 0; m_nv = 0; m_err = 0; m_fv = 0;
  endtask

  task automatic check_a_outputs();
    check("a_out_valid", a_if.out_valid, m_valid);
    if (m_valid) begin
      check("a_out_data", a_if.out_data, m_data);
      check("a_out_clamped", a_if.out_clamped, m_clamp);
      check("a_out_class", a_if.out_class, m_cls);
    end
    check("a_err", err_a, m_err);
    check("a_n_samples", ns_a, m_ns);
    check("a_n_viol", nv_a, m_nv);
    check("a_first_viol", fv_a, m_fv);
  endtask

  // One clock of DUT A: drive at negedge, predict, compare at next negedge.
  task automatic cycle_a(input logic v, input int d, input logic ordy,
                         input logic c);
    int  cls, clamp;
    bit  acc;
    a_if.in_valid  = v;
    a_if.in_data   = 16'(d);
    a_if.out_ready = ordy;
    clr_a          = c;
    #1;
    check("a_in_ready", a_if.in_ready, (!m_valid || ordy));
    acc = v && (!m_valid || ordy);
    ref_class(d, -10, 10, 1, 1, 1, 1, 2, cls, clamp);
    if (c) begin
      m_ns = 0; m_nv = 0; m_err = 0; m_fv = 0;
    end
    if (acc) begin
      m_ns = (m_ns < 255) ? m_ns + 1 : 255;
      if (cls != 0) begin
        m_nv = (m_nv < 255) ? m_nv + 1 : 255;
        if (m_err == 0) begin
          m_err = 1; m_fv = d;
        end
      end
      m_valid = 1; m_data = d; m_cls = cls; m_clamp = clamp;
    end else if (ordy) begin
      m_valid = 0;
    end
    @(posedge clk);
    @(negedge clk);
    a_if.in_valid = 1'b0;
    clr_a         = 1'b0;
    check_a_outputs();
  endtask

  typedef struct {
    int x;
    int cls;
    int clamp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    vec_t v_tmp;
    int   d, cls, clamp;

    tbl[0] = '{x: -11, cls: 1, clamp: -10};
    tbl[1] = '{x: -10, cls: 0, clamp: -10};
    tbl[2] = '{x:   0, cls: 0, clamp:   0};
    tbl[3] = '{x:   1, cls: 3, clamp:   1};
    tbl[4] = '{x:  10, cls: 0, clamp:  10};
    tbl[5] = '{x:  11, cls: 2, clamp:  10};

    a_if.in_valid = 0; a_if.in_data = '0; a_if.out_ready = 0; clr_a = 0;
    b_if.in_valid = 0; b_if.in_data = '0; b_if.out_ready = 1;
    c_if.in_valid = 0; c_if.in_data = '0; c_if.out_ready = 1;
    model_reset();

    // Reset state
    #1;
    check("rst_out_valid", a_if.out_valid, 0);
    check("rst_out_data", a_if.out_data, 0);
    check("rst_out_class", a_if.out_class, 0);
    check("rst_err", err_a, 0);
    check("rst_in_ready", a_if.in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Default range, table-driven
    for (int i = 0; i < 6; i++) begin
      v_tmp = tbl[i];
      cycle_a(1'b1, v_tmp.x, 1'b1, 1'b0);
      check($sformatf("tbl%0d_class", i), a_if.out_class, v_tmp.cls);
      check($sformatf("tbl%0d_clamp", i), a_if.out_clamped, v_tmp.clamp);
    end
    cycle_a(1'b0, 0, 1'b1, 1'b0);
    check("tbl_n_samples", ns_a, 6);
    check("tbl_n_viol", nv_a, 3);
    check("tbl_first_viol", fv_a, -11);
    check("tbl_err", err_a, 1);

    // clr with simultaneous accept while in FAULT
    cycle_a(1'b1, 5, 1'b1, 1'b1);
    check("clr5_err", err_a, 0);
    check("clr5_n_samples", ns_a, 1);
    check("clr5_n_viol", nv_a, 0);
    cycle_a(1'b1, 50, 1'b1, 1'b1);
    check("clr50_err", err_a, 1);
    check("clr50_first_viol", fv_a, 50);
    check("clr50_n_viol", nv_a, 1);
    cycle_a(1'b0, 0, 1'b1, 1'b0);

    // Backpressure: one accept, then stall three cycles, then release
    cycle_a(1'b1, 3, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle_a(1'b1, 4, 1'b0, 1'b0);
      check("bp_in_ready_low", a_if.in_ready, 0);
      check("bp_hold_data", a_if.out_data, 3);
    end
    cycle_a(1'b1, 4, 1'b1, 1'b0);
    check("bp_rel_data4", a_if.out_data, 4);
    cycle_a(1'b1, 5, 1'b1, 1'b0);
    check("bp_rel_data5", a_if.out_data, 5);
    cycle_a(1'b1, 6, 1'b1, 1'b0);
    cycle_a(1'b0, 0, 1'b1, 1'b0);
    check("bp_n_samples", ns_a, 4);

    // Randomized stream against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) d = int'($urandom_range(0, 65535)) - 32768;
      else d = int'($urandom_range(0, 60)) - 30;
      cycle_a($urandom_range(0, 3) != 0, d, $urandom_range(0, 9) < 7,
              $urandom_range(0, 29) == 0);
    end

    // DUT B: exclusive bounds and counter saturation
    @(negedge clk);
    b_if.in_valid = 1; b_if.in_data = -16'sd10;
    @(posedge clk); @(negedge clk);
    check("b_lo_class", b_if.out_class, 1);
    check("b_lo_clamp", b_if.out_clamped, -9);
    b_if.in_data = 16'sd10;
    @(posedge clk); @(negedge clk);
    check("b_hi_class", b_if.out_class, 2);
    check("b_hi_clamp", b_if.out_clamped, 9);
    b_if.in_data = 16'sd100;
    repeat (18) begin
      @(posedge clk); @(negedge clk);
    end
    b_if.in_valid = 0;
    @(posedge clk); @(negedge clk);
    check("b_sat_n_viol", nv_b, 15);
    check("b_sat_n_samples", ns_b, 15);
    check("b_first_viol", fv_b, -10);
    check("b_err", err_b, 1);

    // DUT C: full 8-bit range, no overflow at the extremes
    c_if.in_valid = 1; c_if.in_data = -8'sd128;
    @(posedge clk); @(negedge clk);
    check("c_min_class", c_if.out_class, 0);
    check("c_min_clamp", c_if.out_clamped, -128);
    c_if.in_data = 8'sd127;
    @(posedge clk); @(negedge clk);
    check("c_max_class", c_if.out_class, 0);
    check("c_max_clamp", c_if.out_clamped, 127);
    for (int i = 0; i < 30; i++) begin
      d = int'($urandom_range(0, 255)) - 128;
      c_if.in_data = 8'(d);
      ref_class(d, -128, 127, 1, 1, 0, 1, 2, cls, clamp);
      @(posedge clk); @(negedge clk);
      check("c_rand_class", c_if.out_class, cls);
      check("c_rand_clamp", c_if.out_clamped, clamp);
    end
    c_if.in_valid = 0;
    @(posedge clk); @(negedge clk);
    check("c_n_viol", nv_c, 0);
    check("c_err", err_c, 0);
    check("c_n_samples", ns_c, 32);

    // Async reset while a result is pending
    cycle_a(1'b0, 0, 1'b1, 1'b0);
    cycle_a(1'b1, -20, 1'b0, 1'b0);
    check("pre_rst_valid", a_if.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_out_valid", a_if.out_valid, 0);
    check("mid_rst_out_data", a_if.out_data, 0);
    check("mid_rst_out_clamped", a_if.out_clamped, 0);
    check("mid_rst_out_class", a_if.out_class, 0);
    check("mid_rst_err", err_a, 0);
    check("mid_rst_n_samples", ns_a, 0);
    check("mid_rst_n_viol", nv_a, 0);
    check("mid_rst_first_viol", fv_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle_a(1'b0, 0, 1'b0, 1'b0);
    check("post_rst_in_ready", a_if.in_ready, 1);
    cycle_a(1'b1, 2, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/value_range_checker.md
Name: value_range_checker

Overview:
- Runtime counterpart of declared parameter value ranges: checks a stream of signed integer samples against a range `from [LO:HI]` with an optional `exclude [EX_LO:EX_HI)`.
- Per sample it emits a classification and a clamped value, keeps saturating statistics, and captures the first violation.
- Sits between a value producer and consumer as a one-stage registered pipeline with valid/ready on both sides.

Parameters:
- W, 16, sample width; two's-complement signed.
- LO, -10, lower range bound.
- HI, 10, upper range bound; LO <= HI required.
- LO_INCL, 1, 1 = LO inclusive `[`, 0 = exclusive `(`.
- HI_INCL, 1, 1 = HI inclusive `]`, 0 = exclusive `)`.
- EX_EN, 1, enable exclude window.
- EX_LO, 1, exclude window lower bound, always inclusive.
- EX_HI, 2, exclude window upper bound, always exclusive.
- CNT_W, 8, statistics counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  sample valid.
- in_ready  out  1  checker can accept.
- in_data  in  W  signed sample.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_data  out  W  sample passed through unchanged.
- out_clamped  out  W  clamped sample.
- out_class  out  2  0 = OK, 1 = BELOW, 2 = ABOVE, 3 = EXCLUDED.
- clr  in  1  synchronous clear of statistics and sticky state.
- err  out  1  sticky: a violation has occurred.
- n_samples  out  CNT_W  accepted samples, saturating.
- n_viol  out  CNT_W  violations, saturating.
- first_viol  out  W  first violating sample since reset or clr.

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_data=0, out_clamped=0, out_class=0, err=0, n_samples=0, n_viol=0, first_viol=0. in_ready=1 after reset.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A sample is accepted when in_valid && in_ready.
  - Latency is 1 cycle: the result is registered on the accept edge.
  - out_valid drops when out_ready is high and no new accept occurs.
  - Full throughput is 1 sample/cycle.
  - Output fields stay stable while out_valid && !out_ready.
- Classification uses signed compare at W+1 bits to avoid overflow. Priority order:
  - BELOW: x < LO, or x == LO with LO_INCL=0.
  - ABOVE: x > HI, or x == HI with HI_INCL=0.
  - EXCLUDED: EX_EN && EX_LO <= x < EX_HI.
  - OK: otherwise.
- Clamp:
  - BELOW → LO if LO_INCL, else LO+1.
  - ABOVE → HI if HI_INCL, else HI-1.
  - OK and EXCLUDED → x unchanged.
- Violation = class != OK.
- Sticky FSM, states CLEAN and FAULT:
  - CLEAN → FAULT on an accepted violation; first_viol captures that sample on the same edge.
  - FAULT → CLEAN only on clr.
  - err = (state == FAULT).
- Counters:
  - n_samples increments on each accept.
  - n_viol increments on each accepted violation.
  - Both hold at 2^CNT_W-1 (no wrap).
- clr with a simultaneous accept: clear first, then apply that sample, i.e.:
  - n_samples=1.
  - n_viol = violation ? 1 : 0.
  - A violating sample re-enters FAULT and is captured in first_viol.
- clr does not affect the pipeline (out_valid and output fields).
- Async reset mid-stream drops any pending output; the sample in flight is lost and not counted.
- EX_EN=0 or EX_LO >= EX_HI disables EXCLUDED entirely.

Test Plan:
- Defaults; send -11, -10, 0, 1, 10, 11 with out_ready=1 → class BELOW, OK, OK, EXCLUDED, OK, ABOVE; clamped -10, -10, 0, 1, 10, 10; n_samples=6, n_viol=3, first_viol=-11, err=1.
- LO_INCL=0, HI_INCL=0; send -10 and 10 → BELOW with clamped -9; ABOVE with clamped 9.
- W=8, LO=-128, HI=127, EX_EN=0; send -128 and 127 → both OK, no overflow; n_viol=0, err=0.
- Backpressure:
  - hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 after the first accept and the output holds.
  - Release → one result per cycle, and n_samples counts each sample exactly once.
- CNT_W=4; send 20 violations → n_viol saturates at 15, n_samples saturates at 15.
- Pulse clr together with accept of sample 5 while in FAULT → err=0, n_samples=1, n_viol=0. Then pulse clr with sample 50 → err=1, first_viol=50.
- Assert rst_n low while out_valid=1 → all outputs 0 immediately; in_ready=1 after release.
